// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-write buffer between a pipelined core's data port and a data RAM.
// The core's stores go into a small circular FIFO in one cycle. The buffer
// writes them to RAM, oldest first, on cycles when the core does not use the
// data port. A load returns the data of the youngest buffered store to the
// same address. If no buffered store matches, it returns the RAM read data.
// The core therefore always sees memory in program order.
//
// Optional feature (macro STORE_BUFFER_COALESCE_EN):
//   When defined, a store whose address matches a buffered entry overwrites
//   that entry's data in place. Such a store does not push and does not drain.
//   The buffer then holds at most one entry per address.
//   When undefined, every store allocates a new entry.
//
// Parameters:
//   DEPTH  number of buffered stores (power of two, 2..16)
//   AW     word address width
//   DW     data width
//
// Ports:
//   CLK          system clock, rising edge
//   RSTn         asynchronous active-low reset; discards all pending stores
//   cpu_d_w      core store request
//   cpu_d_r      core load request (store wins if both are set)
//   cpu_daddr    core data address
//   cpu_ddata_w  core store data
//   cpu_ddata_r  load data to core (combinational, 0 outside a load)
//   mem_we       RAM write enable (RAM writes on rising edge)
//   mem_re       RAM read enable
//   mem_addr     RAM address (0 when the RAM is not in use)
//   mem_wdata    RAM write data (0 when not writing)
//   mem_rdata    RAM read data (combinational from mem_addr)
//   empty        no stores pending
//   count        number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     cpu_d_w,
    input  logic                     cpu_d_r,
    input  logic [AW-1:0]            cpu_daddr,
    input  logic [DW-1:0]            cpu_ddata_w,
    output logic [DW-1:0]            cpu_ddata_r,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    logic          is_load;
    logic          full;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic          push;
    logic          pop;
    logic          do_coalesce;
`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] hit_idx;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A load is a read request without a store. When both requests are set,
    // the cycle is handled as a store.
    assign is_load = cpu_d_r & ~cpu_d_w;

    // Scan the valid entries from oldest to youngest. A later match
    // overwrites an earlier one, so the youngest matching store wins.
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path through the block can leave a latch behind.
    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
`ifdef STORE_BUFFER_COALESCE_EN
        hit_idx  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == cpu_daddr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
`ifdef STORE_BUFFER_COALESCE_EN
                hit_idx  = idx;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_COALESCE_EN
    assign do_coalesce = cpu_d_w & hit;
`else
    assign do_coalesce = 1'b0;
`endif

    // The buffer drains on an idle cycle. It also drains on a store that
    // finds it full: the head leaves at the same edge the new entry arrives,
    // and the write goes to the old head slot, so the order stays FIFO.
    assign push = cpu_d_w & ~do_coalesce;
    assign pop  = ~empty & ((~cpu_d_w & ~cpu_d_r) | (push & full));

    always_comb begin
        mem_we      = pop;
        mem_re      = is_load;
        mem_addr    = '0;
        mem_wdata   = '0;
        cpu_ddata_r = '0;
        if (is_load) begin
            mem_addr    = cpu_daddr;
            cpu_ddata_r = hit ? hit_data : mem_rdata;
        end else if (pop) begin
            mem_addr  = addr_q[head_q];
            mem_wdata = data_q[head_q];
        end
    end

    // Pointers and occupancy. Pointers wrap naturally at the power-of-two depth.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its inputs as they were before the clock edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage. An entry is ignored unless it lies between head and
    // count, so its contents never need clearing.
    // NOTE: the storage array has no reset. The pointers alone define which
    // entries are valid, and leaving the array out of reset lets it map to
    // plain RAM cells.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail_q] <= cpu_daddr;
            data_q[tail_q] <= cpu_ddata_w;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        if (do_coalesce) data_q[hit_idx] <= cpu_ddata_w;
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed testbench for store_buffer with DEPTH=4, AW=10, DW=32.
// A 2-state RAM model in the bench starts at all zeros and writes on the
// rising edge when mem_we is high. Inputs change at the falling edge.
// Combinational outputs are sampled 1 ns later. Registered state is sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;

    logic            CLK;
    logic            RSTn;
    logic            cpu_d_w;
    logic            cpu_d_r;
    logic [AW-1:0]   cpu_daddr;
    logic [DW-1:0]   cpu_ddata_w;
    logic [DW-1:0]   cpu_ddata_r;
    logic            mem_we;
    logic            mem_re;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            empty;
    logic [2:0]      count;

    int n_cmp  = 0;
    int n_fail = 0;

    bit [DW-1:0] ram [1024];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .cpu_d_w     (cpu_d_w),
        .cpu_d_r     (cpu_d_r),
        .cpu_daddr   (cpu_daddr),
        .cpu_ddata_w (cpu_ddata_w),
        .cpu_ddata_r (cpu_ddata_r),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .empty       (empty),
        .count       (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_rdata = ram[mem_addr];
    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    // Drive one cycle's request at the falling edge, then let it settle.
    task automatic set_in(input logic w, input logic r,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        cpu_d_w     = w;
        cpu_d_r     = r;
        cpu_daddr   = a;
        cpu_ddata_w = d;
        #1;
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        cpu_d_w = 0; cpu_d_r = 0; cpu_daddr = '0; cpu_ddata_w = '0;
        RSTn = 1'b0;
        #12;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if ({mem_we, mem_re} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en: got we=%b re=%b want 0/0", mem_we, mem_re); end
        n_cmp++; if (cpu_ddata_r !== 32'h0) begin n_fail++; $display("FAIL reset_ddata_r: got %h want 0", cpu_ddata_r); end
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic test_back_to_back();
        set_in(1, 0, 10'd5, 32'h11111111);
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_st1_we: got %b want 0", mem_we); end
        after_edge();
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count1: got %0d want 1", count); end
        set_in(1, 0, 10'd6, 32'h22222222);
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_st2_we: got %b want 0", mem_we); end
        after_edge();
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count2: got %0d want 2", count); end
        set_in(0, 0, 10'd0, 32'h0);
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd5, 32'h11111111})
            begin n_fail++; $display("FAIL b2b_drain1: got we=%b a=%0d d=%h want 1/5/11111111", mem_we, mem_addr, mem_wdata); end
        after_edge();
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count3: got %0d want 1", count); end
        n_cmp++; if ({ram[5], ram[6]} !== {32'h11111111, 32'h0})
            begin n_fail++; $display("FAIL b2b_ram_order: got ram5=%h ram6=%h want 11111111/0", ram[5], ram[6]); end
        set_in(0, 0, 10'd0, 32'h0);
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd6, 32'h22222222})
            begin n_fail++; $display("FAIL b2b_drain2: got we=%b a=%0d d=%h want 1/6/22222222", mem_we, mem_addr, mem_wdata); end
        after_edge();
        n_cmp++; if ({count, empty} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL b2b_count4: got %0d empty=%b want 0/1", count, empty); end
        n_cmp++; if (ram[6] !== 32'h22222222) begin n_fail++; $display("FAIL b2b_ram6: got %h want 22222222", ram[6]); end
        set_in(0, 0, 10'd0, 32'h0);
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 10'd0, 32'h0})
            begin n_fail++; $display("FAIL b2b_idle_empty: got we=%b a=%0d d=%h want 0/0/0", mem_we, mem_addr, mem_wdata); end
    endtask

    task automatic test_forward();
        set_in(1, 0, 10'd9, 32'hDEADBEEF);
        after_edge();
        set_in(0, 1, 10'd9, 32'h0);
        n_cmp++; if (cpu_ddata_r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_data: got %h want deadbeef", cpu_ddata_r); end
        n_cmp++; if ({mem_we, mem_re, mem_addr} !== {1'b0, 1'b1, 10'd9})
            begin n_fail++; $display("FAIL fwd_mem: got we=%b re=%b a=%0d want 0/1/9", mem_we, mem_re, mem_addr); end
        after_edge();
        n_cmp++; if ({ram[9], count} !== {32'h0, 3'd1}) begin n_fail++; $display("FAIL fwd_no_drain: got ram9=%h count=%0d want 0/1", ram[9], count); end
        set_in(0, 0, 10'd0, 32'h0);
        after_edge();
        n_cmp++; if ({ram[9], count} !== {32'hDEADBEEF, 3'd0}) begin n_fail++; $display("FAIL fwd_drain: got ram9=%h count=%0d want deadbeef/0", ram[9], count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, AW'(i), 32'h100 + DW'(i));
            n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL full_fill_we%0d: got %b want 0", i, mem_we); end
            after_edge();
            n_cmp++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL full_fill_count%0d: got %0d want %0d", i, count, i + 1); end
        end
        set_in(1, 0, 10'd4, 32'h104);
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd0, 32'h100})
            begin n_fail++; $display("FAIL full_push_drain: got we=%b a=%0d d=%h want 1/0/100", mem_we, mem_addr, mem_wdata); end
        after_edge();
        n_cmp++; if ({count, ram[0]} !== {3'd4, 32'h100}) begin n_fail++; $display("FAIL full_steady: got count=%0d ram0=%h want 4/100", count, ram[0]); end
        for (int i = 1; i <= 4; i++) begin
            set_in(0, 0, 10'd0, 32'h0);
            n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(i), 32'h100 + DW'(i)})
                begin n_fail++; $display("FAIL full_drain%0d: got we=%b a=%0d d=%h want 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, i, 32'h100 + i); end
            after_edge();
            n_cmp++; if (count !== 3'(4 - i)) begin n_fail++; $display("FAIL full_drain_count%0d: got %0d want %0d", i, count, 4 - i); end
        end
    endtask

    task automatic test_duplicate();
        int budget;
        set_in(1, 0, 10'd7, 32'hA);
        after_edge();
        set_in(1, 0, 10'd7, 32'hB);
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL dup_we: got %b want 0", mem_we); end
        after_edge();
        set_in(0, 1, 10'd7, 32'h0);
        n_cmp++; if (cpu_ddata_r !== 32'hB) begin n_fail++; $display("FAIL dup_youngest: got %h want b", cpu_ddata_r); end
`ifdef STORE_BUFFER_COALESCE_EN
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL dup_count: got %0d want 1", count); end
`else
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL dup_count: got %0d want 2", count); end
`endif
        after_edge();
        budget = 8;
        while (!empty && budget > 0) begin
            set_in(0, 0, 10'd0, 32'h0);
            after_edge();
            budget--;
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL dup_drain_timeout: got empty=%b want 1", empty); end
        n_cmp++; if (ram[7] !== 32'hB) begin n_fail++; $display("FAIL dup_ram7: got %h want b", ram[7]); end
    endtask

    task automatic test_load_miss();
        set_in(1, 0, 10'd3, 32'h12345678);
        after_edge();
        set_in(0, 0, 10'd0, 32'h0);
        after_edge();
        set_in(0, 1, 10'd3, 32'h0);
        n_cmp++; if (cpu_ddata_r !== 32'h12345678) begin n_fail++; $display("FAIL miss_data: got %h want 12345678", cpu_ddata_r); end
        n_cmp++; if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd3})
            begin n_fail++; $display("FAIL miss_mem: got re=%b we=%b a=%0d want 1/0/3", mem_re, mem_we, mem_addr); end
        // Both requests at once are handled as a store.
        set_in(1, 1, 10'd3, 32'h55);
        n_cmp++; if ({cpu_ddata_r, mem_re} !== {32'h0, 1'b0}) begin n_fail++; $display("FAIL illegal_out: got d=%h re=%b want 0/0", cpu_ddata_r, mem_re); end
        after_edge();
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL illegal_push: got %0d want 1", count); end
        set_in(0, 0, 10'd0, 32'h0);
        after_edge();
        n_cmp++; if (ram[3] !== 32'h55) begin n_fail++; $display("FAIL illegal_ram3: got %h want 55", ram[3]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 10'd20 + AW'(i), 32'hC0 + DW'(i));
            after_edge();
        end
        set_in(0, 0, 10'd0, 32'h0);
        n_cmp++; if ({count, mem_we, mem_addr} !== {3'd3, 1'b1, 10'd20})
            begin n_fail++; $display("FAIL rst_pre: got count=%0d we=%b a=%0d want 3/1/20", count, mem_we, mem_addr); end
        #1 RSTn = 1'b0;
        #1;
        n_cmp++; if ({count, empty} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL rst_async: got count=%0d empty=%b want 0/1", count, empty); end
        n_cmp++; if ({mem_we, mem_re, cpu_ddata_r} !== {1'b0, 1'b0, 32'h0})
            begin n_fail++; $display("FAIL rst_async_out: got we=%b re=%b d=%h want 0/0/0", mem_we, mem_re, cpu_ddata_r); end
        @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 10'd0, 32'h0);
            n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_post_we%0d: got %b want 0", i, mem_we); end
            after_edge();
        end
        n_cmp++; if (ram[20] !== 32'h0) begin n_fail++; $display("FAIL rst_lost: got ram20=%h want 0", ram[20]); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_forward();
        test_full();
        test_duplicate();
        test_load_miss();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the data port of `CPU_Core_Pipelined` and the data `RAM`. Stores from the core are absorbed into a small FIFO in one cycle and drained to RAM on cycles when the core does not use the data port. Loads are forwarded from the youngest matching buffered store, so the core always sees program-order memory. The core-side port mirrors the core's `daddr/ddata_w/ddata_r/d_w/d_r`; the RAM-side port mirrors RAM's `address/write_data/read_data/MemWrite/MemRead`.

## Interface
- `DEPTH`, 4: number of buffered stores; power of two, 2..16.
- `AW`, 10: word address width.
- `DW`, 32: data width.

- `CLK`  in  1  system clock; all state updates on rising edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `cpu_d_w`  in  1  core store request this cycle.
- `cpu_d_r`  in  1  core load request this cycle.
- `cpu_daddr`  in  AW  core data address.
- `cpu_ddata_w`  in  DW  core store data.
- `cpu_ddata_r`  out  DW  load data to core (combinational).
- `mem_we`  out  1  RAM write enable (RAM writes on rising edge).
- `mem_re`  out  1  RAM read enable.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM read data (combinational from `mem_addr`).
- `empty`  out  1  no stores pending.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- State: circular FIFO of {addr, data}; head/tail pointers, `count`.
- Cycle classes, decided combinationally each cycle:
  - LOAD (`cpu_d_r`=1, `cpu_d_w`=0): `mem_re`=1, `mem_addr`=`cpu_daddr`, `mem_we`=0; no drain. `cpu_ddata_r` = data of youngest entry with addr == `cpu_daddr`, else `mem_rdata`.
  - STORE (`cpu_d_w`=1): entry {`cpu_daddr`,`cpu_ddata_w`} pushed at tail. If not full: no drain, `mem_we`=0. If full: head driven to RAM (`mem_we`=1) and popped at the same edge as the push; `count` unchanged.
  - IDLE (neither): if not empty, head driven to RAM (`mem_we`=1, `mem_addr`/`mem_wdata` = head) and popped.
  - `cpu_d_w` and `cpu_d_r` both 1: illegal; treated as STORE, `cpu_ddata_r`=0, `mem_re`=0.
- Outside LOAD, `cpu_ddata_r`=0. When `mem_we`=0 and `mem_re`=0, `mem_addr`=0 and `mem_wdata`=0.
- Drain order strictly FIFO; RAM never sees stores reordered.
- Arithmetic: pointers wrap modulo DEPTH; `count` ranges 0..DEPTH, never overflows.

## Timing
- Store latency to core: 0 (accepted at the edge ending the request cycle); the core never stalls.
- Store reaches RAM at the first IDLE or full-STORE cycle after all older entries have drained.
- Load: combinational, same cycle; forwarding hit and miss have identical latency.
- Store immediately followed by load to same address: forwarded from buffer.
- Reset (any time, including mid-drain): all entries discarded, pointers 0, `count`=0, `empty`=1; with core inputs low, `mem_we`=0, `mem_re`=0, `cpu_ddata_r`=0. Pending stores are lost.

## Configuration
- `STORE_BUFFER_COALESCE_EN` defined: a STORE whose address matches a valid entry overwrites that entry's data in place; no push, no drain, `count` unchanged even when full. At most one entry per address.
- Not defined: every STORE allocates a new entry; duplicate addresses may coexist and forwarding picks the youngest. Drained RAM contents are identical either way.

## Test plan
- Reset, then store 0x11111111 @5, store 0x22222222 @6 back-to-back, then 2 idle cycles -> `count` 1,2,1,0; `mem_we` high only in the idle cycles, RAM[5]/RAM[6] written in order.
- Store 0xDEADBEEF @9 then load @9 next cycle -> `cpu_ddata_r`=0xDEADBEEF, RAM[9] still old value, `mem_we`=0 during load.
- Five consecutive stores @0..@4 (DEPTH=4) -> fifth cycle `mem_we`=1, `mem_addr`=0, `count` stays 4; subsequent idles drain @1..@4.
- Stores 0xA @7 then 0xB @7, then load @7 -> returns 0xB; without macro `count`=2 and RAM[7] ends 0xB; with macro `count`=1.
- Load @3 with empty buffer, RAM[3]=0x12345678 -> `cpu_ddata_r`=0x12345678, `mem_re`=1.
- Three stores buffered, assert `RSTn`=0 asynchronously mid-cycle -> `count`=0, `empty`=1 immediately; no further `mem_we` after release with idle inputs.
